// File: rtl/alu_pkg.sv
// Shared op-code constants and controller state encoding for seq_alu.
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_REM = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/rem_unit.sv
// One restoring-division step: shift in a numerator bit, subtract the
// denominator if it fits.
module rem_unit #(
  parameter int W = 3
) (
  input  logic [W-1:0] prem_in,
  input  logic         num_bit,
  input  logic [W-1:0] den,
  output logic [W-1:0] prem_out
);
  logic [W:0] trial;
  logic [W:0] den_ext;
  logic [W:0] diff;

  always_comb begin
    trial   = {prem_in, num_bit};
    den_ext = {1'b0, den};
    diff    = trial - den_ext;
    // prem_in < den keeps the restored value below den, so W bits suffice
    prem_out = (trial >= den_ext) ? diff[W-1:0] : trial[W-1:0];
  end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub, W-cycle shift-add multiply and
// restoring-division remainder, with start/done handshake and result flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int W  = 3,
  localparam int RW = 2 * W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    sel,
  input  logic [W-1:0]  num1,
  input  logic [W-1:0]  num2,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          zero_flag,
  output logic          div_by_zero_flag
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_e        state, state_next;
  logic          accept;
  logic          last;
  logic [CW-1:0] cnt;
  logic [1:0]    op;
  logic [RW-1:0] mcand, acc, acc_next;
  logic [W-1:0]  mplier, numer, den, prem, prem_next;
  logic [RW-1:0] fast_res, calc_res;

  assign last = (cnt == CW'(W - 1));
  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (sel == OP_MUL || (sel == OP_REM && num2 != '0)) ? CALC : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      CALC:    if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (sel)
      OP_ADD:  fast_res = RW'(num1) + RW'(num2);
      OP_SUB:  fast_res = RW'(num1) - RW'(num2);
      default: fast_res = '0;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  rem_unit #(.W(W)) u_rem (
    .prem_in  (prem),
    .num_bit  (numer[W-1]),
    .den      (den),
    .prem_out (prem_next)
  );

  assign calc_res = (op == OP_MUL) ? acc_next : RW'(prem_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // result/flags only move on an accepted single-cycle op or the last iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op               <= '0;
      cnt              <= '0;
      mcand            <= '0;
      acc              <= '0;
      mplier           <= '0;
      numer            <= '0;
      den              <= '0;
      prem             <= '0;
      result           <= '0;
      zero_flag        <= 1'b0;
      div_by_zero_flag <= 1'b0;
    end else if (accept) begin
      op     <= sel;
      cnt    <= '0;
      mcand  <= RW'(num1);
      acc    <= '0;
      mplier <= num2;
      numer  <= num1;
      den    <= num2;
      prem   <= '0;
      if (sel == OP_ADD || sel == OP_SUB) begin
        result           <= fast_res;
        zero_flag        <= (fast_res == '0);
        div_by_zero_flag <= 1'b0;
      end else if (sel == OP_REM && num2 == '0) begin
        result           <= '0;
        zero_flag        <= 1'b0;
        div_by_zero_flag <= 1'b1;
      end
    end else if (state == CALC) begin
      cnt    <= cnt + 1'b1;
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      numer  <= numer << 1;
      prem   <= prem_next;
      if (last) begin
        result           <= calc_res;
        zero_flag        <= (calc_res == '0);
        div_by_zero_flag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at W=3 (vector table + handshake corners) and W=8 (sweep).
`timescale 1ns/1ps
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st3 = 1'b0;
  logic [1:0] sel3 = '0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, zf3, dz3;
  logic [5:0] res3;

  logic       st8 = 1'b0;
  logic [1:0] sel8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, zf8, dz8;
  logic [15:0] res8;

  seq_alu #(.W(3)) d3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .sel(sel3), .num1(a3), .num2(b3),
    .busy(busy3), .done(done3), .result(res3), .zero_flag(zf3), .div_by_zero_flag(dz3)
  );

  seq_alu #(.W(8)) d8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sel(sel8), .num1(a8), .num2(b8),
    .busy(busy8), .done(done8), .result(res8), .zero_flag(zf8), .div_by_zero_flag(dz8)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] s;
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] r;
    logic       z;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t v[13];

  // Issue one op on the W=3 instance; latency 1 means done right after the accepting edge.
  task automatic run3(input logic [1:0] s, input logic [2:0] x, input logic [2:0] y,
                      output logic [5:0] r, output logic z, output logic dz,
                      output int lat, output int nbusy, output bit stable);
    logic [5:0] prev;
    @(negedge clk);
    sel3 = s; a3 = x; b3 = y; st3 = 1'b1;
    prev = res3; stable = 1'b1; nbusy = 0;
    @(posedge clk); #1 st3 = 1'b0;
    lat = 1;
    while (!done3 && lat < 40) begin
      if (busy3) nbusy++;
      if (res3 !== prev) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    r = res3; z = zf3; dz = dz3;
  endtask

  task automatic run8(input logic [1:0] s, input logic [7:0] x, input logic [7:0] y,
                      output logic [15:0] r, output logic z, output logic dz, output int lat);
    @(negedge clk);
    sel8 = s; a8 = x; b8 = y; st8 = 1'b1;
    @(posedge clk); #1 st8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res8; z = zf8; dz = dz8;
  endtask

  initial begin
    logic [5:0]  r;
    logic [15:0] r16, e16;
    logic        z, dz, edz;
    int          lat, nb, elat;
    bit          stable;
    logic [7:0]  vals[15];

    v[0]  = '{OP_ADD, 3'd7, 3'd7, 6'd14,        1'b0, 1'b0, 1};
    v[1]  = '{OP_ADD, 3'd0, 3'd0, 6'd0,         1'b1, 1'b0, 1};
    v[2]  = '{OP_SUB, 3'd2, 3'd5, 6'b111101,    1'b0, 1'b0, 1};
    v[3]  = '{OP_SUB, 3'd3, 3'd3, 6'd0,         1'b1, 1'b0, 1};
    v[4]  = '{OP_SUB, 3'd5, 3'd2, 6'd3,         1'b0, 1'b0, 1};
    v[5]  = '{OP_MUL, 3'd7, 3'd7, 6'd49,        1'b0, 1'b0, 4};
    v[6]  = '{OP_MUL, 3'd0, 3'd5, 6'd0,         1'b1, 1'b0, 4};
    v[7]  = '{OP_MUL, 3'd3, 3'd6, 6'd18,        1'b0, 1'b0, 4};
    v[8]  = '{OP_REM, 3'd7, 3'd3, 6'd1,         1'b0, 1'b0, 4};
    v[9]  = '{OP_REM, 3'd6, 3'd3, 6'd0,         1'b1, 1'b0, 4};
    v[10] = '{OP_REM, 3'd5, 3'd0, 6'd0,         1'b0, 1'b1, 1};
    v[11] = '{OP_REM, 3'd7, 3'd1, 6'd0,         1'b1, 1'b0, 4};
    v[12] = '{OP_REM, 3'd2, 3'd7, 6'd2,         1'b0, 1'b0, 4};

    vals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd8, 8'd15, 8'd16, 8'd85,
             8'd127, 8'd128, 8'd170, 8'd200, 8'd254, 8'd255};

    #1;
    chk("rst_busy",   busy3, 0);
    chk("rst_done",   done3, 0);
    chk("rst_result", res3,  0);
    chk("rst_zf",     zf3,   0);
    chk("rst_dz",     dz3,   0);
    chk("rst_result8", res8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run3(v[i].s, v[i].a, v[i].b, r, z, dz, lat, nb, stable);
      chk($sformatf("v%0d_result", i), r,   v[i].r);
      chk($sformatf("v%0d_zero", i),   z,   v[i].z);
      chk($sformatf("v%0d_dbz", i),    dz,  v[i].dz);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      if (v[i].lat > 1) begin
        chk($sformatf("v%0d_busy_cycles", i), nb, 3);
        chk($sformatf("v%0d_result_stable", i), stable, 1);
      end
    end

    // Reset in the middle of a multiply; previous result (2) must be cleared.
    @(negedge clk);
    sel3 = OP_MUL; a3 = 3'd7; b3 = 3'd7; st3 = 1'b1;
    @(posedge clk); #1 st3 = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_busy", busy3, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   busy3, 0);
    chk("midrst_done",   done3, 0);
    chk("midrst_result", res3,  0);
    chk("midrst_zf",     zf3,   0);
    chk("midrst_dz",     dz3,   0);
    @(negedge clk);
    rst_n = 1'b1;
    run3(OP_ADD, 3'd7, 3'd7, r, z, dz, lat, nb, stable);
    chk("post_rst_add", r, 14);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_zf", z, 0);

    // Start pulsed during busy with different operands is ignored.
    @(negedge clk);
    sel3 = OP_MUL; a3 = 3'd7; b3 = 3'd7; st3 = 1'b1;
    @(posedge clk); #1 st3 = 1'b0;
    @(negedge clk);
    sel3 = OP_ADD; a3 = 3'd1; b3 = 3'd1; st3 = 1'b1;
    @(negedge clk);
    st3 = 1'b0;
    lat = 2;
    while (!done3 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore_result", res3, 49);
    chk("ignore_lat", lat, 4);
    @(posedge clk); #1;
    chk("ignore_no_requeue", done3 | busy3, 0);

    // Start held through the done cycle: next op begins without an idle gap.
    @(negedge clk);
    sel3 = OP_MUL; a3 = 3'd3; b3 = 3'd5; st3 = 1'b1;
    @(posedge clk); #1;
    a3 = 3'd6; b3 = 3'd7;
    lat = 1;
    while (!done3 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_first_result", res3, 15);
    chk("b2b_first_lat", lat, 4);
    @(posedge clk); #1;
    chk("b2b_no_gap_busy", busy3, 1);
    chk("b2b_no_gap_done", done3, 0);
    st3 = 1'b0;
    lat = 1;
    while (!done3 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_second_result", res3, 42);
    chk("b2b_second_lat", lat, 4);

    // W=8 sweep over a spread of operand values.
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < 15; j++) begin
        for (int k = 0; k < 4; k++) begin
          edz  = 1'b0;
          elat = 1;
          case (k)
            0: e16 = {8'd0, vals[i]} + {8'd0, vals[j]};
            1: e16 = {8'd0, vals[i]} - {8'd0, vals[j]};
            2: begin e16 = 16'(vals[i] * vals[j]); elat = 9; end
            default: begin
              if (vals[j] == 0) begin e16 = '0; edz = 1'b1; end
              else begin e16 = {8'd0, vals[i] % vals[j]}; elat = 9; end
            end
          endcase
          run8(2'(k), vals[i], vals[j], r16, z, dz, lat);
          chk($sformatf("w8_op%0d_%0d_%0d_result", k, vals[i], vals[j]), r16, e16);
          chk($sformatf("w8_op%0d_%0d_%0d_zero", k, vals[i], vals[j]), z, (e16 == 0) && !edz);
          chk($sformatf("w8_op%0d_%0d_%0d_dbz", k, vals[i], vals[j]), dz, edz);
          chk($sformatf("w8_op%0d_%0d_%0d_lat", k, vals[i], vals[j]), lat, elat);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
